// File: rtl/ovr_i_guard.sv
// ---------------------------------------------------------------------------
// ovr_i_guard
//   Overcurrent guard for a PWM motor drive.  Each PWM period opens with a
//   blanking window (switching transients are ignored), followed by a sample
//   window in which any overcurrent marks the period as faulted.  A run of
//   MAX_STRIKES consecutive faulted periods latches a shutdown request that
//   only reset can clear.  A clean period clears the strike count.
//
// Parameters
//   BLANK_CYC    cycles after each PWM period start during which overcurrent
//                is ignored
//   MAX_STRIKES  consecutive faulted periods that latch shutdown (1..63)
//
// Ports
//   clk           system clock, all flops on its rising edge
//   rst           synchronous active-high reset
//   PWM_synch     one-cycle pulse at each PWM period start
//   OVR_I_lft     asynchronous left motor overcurrent flag
//   OVR_I_rght    asynchronous right motor overcurrent flag
//   OVR_I_shtdwn  latched shutdown request (registered)
//   ovr_evt       one-cycle pulse after a period closes faulted (registered)
//   strikes       count of consecutive faulted periods (registered)
// ---------------------------------------------------------------------------
module ovr_i_guard #(
   parameter int BLANK_CYC   = 128,
   parameter int MAX_STRIKES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       PWM_synch,
   input  logic       OVR_I_lft,
   input  logic       OVR_I_rght,
   output logic       OVR_I_shtdwn,
   output logic       ovr_evt,
   output logic [5:0] strikes
);

   localparam int               CNT_W      = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BLANK_CYC - 1);
   localparam logic [5:0]       STRIKE_MAX = 6'(MAX_STRIKES);
   localparam logic [5:0]       STRIKE_SAT = 6'd63;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SAMPLE,
      SHUTDOWN
   } state_t;

   // Saturating strike increment.
   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      return (v == STRIKE_SAT) ? v : v + 6'd1;
   endfunction

   // Synchronizer stages: the raw flags are only ever seen by these flops.
   logic lft_s1_q, lft_s2_q;
   logic rgt_s1_q, rgt_s2_q;
   logic ovr_s;

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             flag_q,    flag_d;
   logic [5:0]       strikes_q, strikes_d;
   logic             shtdwn_q,  shtdwn_d;
   logic             evt_q,     evt_d;
   logic [5:0]       strikes_inc;

   assign ovr_s       = lft_s2_q | rgt_s2_q;
   assign strikes_inc = sat_inc(strikes_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      flag_d    = flag_q;
      strikes_d = strikes_q;
      shtdwn_d  = shtdwn_q;
      evt_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (PWM_synch) begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         end

         BLANK: begin
            if (PWM_synch) begin
               // Period shorter than the blanking window: never sampled,
               // so it counts as clean and blanking starts over.
               cnt_d     = '0;
               flag_d    = 1'b0;
               strikes_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         SAMPLE: begin
            if (PWM_synch) begin
               cnt_d   = '0;
               flag_d  = 1'b0;
               state_d = BLANK;
               // A fault seen on the closing cycle itself still counts.
               if (flag_q || ovr_s) begin
                  strikes_d = strikes_inc;
                  evt_d     = 1'b1;
                  if (strikes_inc == STRIKE_MAX) begin
                     state_d  = SHUTDOWN;
                     shtdwn_d = 1'b1;
                  end
               end else begin
                  strikes_d = '0;
               end
            end else if (ovr_s) begin
               flag_d = 1'b1;
            end
         end

         SHUTDOWN: begin
            shtdwn_d = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lft_s1_q  <= 1'b0;
         lft_s2_q  <= 1'b0;
         rgt_s1_q  <= 1'b0;
         rgt_s2_q  <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         flag_q    <= 1'b0;
         strikes_q <= '0;
         shtdwn_q  <= 1'b0;
         evt_q     <= 1'b0;
      end else begin
         lft_s1_q  <= OVR_I_lft;
         lft_s2_q  <= lft_s1_q;
         rgt_s1_q  <= OVR_I_rght;
         rgt_s2_q  <= rgt_s1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         flag_q    <= flag_d;
         strikes_q <= strikes_d;
         shtdwn_q  <= shtdwn_d;
         evt_q     <= evt_d;
      end
   end

   assign OVR_I_shtdwn = shtdwn_q;
   assign ovr_evt      = evt_q;
   assign strikes      = strikes_q;

endmodule
